// File: rtl/hc_pkg.sv
// hc_pkg: shared types and default widths for the loopback datapath.
// LOOPBACK_WRITER_FENCE_EN adds the FENCE/FWAIT writer states.
package hc_pkg;

  localparam int CL_DATA_W  = 512;
  localparam int CL_ADDR_W  = 42;
  localparam int CL_MDATA_W = 16;

  typedef logic [CL_ADDR_W-1:0] t_cl_addr;
  typedef logic [CL_DATA_W-1:0] t_cl_data;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_RUN,
    WR_DRAIN,
    WR_DONE
`ifdef LOOPBACK_WRITER_FENCE_EN
    ,
    WR_FENCE,
    WR_FWAIT
`endif
  } t_writer_state;

endpackage

// File: rtl/loopback_writer_if.sv
// loopback_writer_if: FIFO-side and write-channel signals of the writer.
// LOOPBACK_WRITER_FENCE_EN adds the fence request/response pair.
interface loopback_writer_if #(
  parameter int DATA_WIDTH  = hc_pkg::CL_DATA_W,
  parameter int ADDR_WIDTH  = hc_pkg::CL_ADDR_W,
  parameter int MDATA_WIDTH = hc_pkg::CL_MDATA_W
);

  logic [DATA_WIDTH-1:0]  fifo_data;
  logic                   fifo_empty;
  logic                   fifo_deq;
  logic                   wr_almost_full;
  logic                   wr_valid;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [MDATA_WIDTH-1:0] wr_mdata;
  logic                   wr_rsp_valid;
`ifdef LOOPBACK_WRITER_FENCE_EN
  logic                   wr_fence;
  logic                   wr_fence_rsp;
`endif

  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  wr_almost_full,
    input  wr_rsp_valid,
`ifdef LOOPBACK_WRITER_FENCE_EN
    input  wr_fence_rsp,
    output wr_fence,
`endif
    output fifo_deq,
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_mdata
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    output wr_almost_full,
    output wr_rsp_valid,
`ifdef LOOPBACK_WRITER_FENCE_EN
    output wr_fence_rsp,
    input  wr_fence,
`endif
    input  fifo_deq,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_mdata
  );

endinterface

// File: rtl/loopback_writer_credit.sv
// loopback_writer_credit: issued/response counters, credit flag, sticky err.
// No build macros.
module loopback_writer_credit #(
  parameter int CNT_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 issue_i,
  input  logic                 rsp_i,
  input  logic                 active_i,
  output logic [CNT_WIDTH-1:0] issued_o,
  output logic [CNT_WIDTH-1:0] resp_o,
  output logic                 credit_o,
  output logic                 err_o
);

  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] resp_q, resp_d;
  logic [CNT_WIDTH-1:0] outstanding;
  logic                 err_q, err_d;
  logic                 quiet_q, quiet_d;
  logic                 rsp_ok;

  assign outstanding = issued_q - resp_q;
  assign rsp_ok      = rsp_i && active_i && (outstanding != '0);
  assign credit_o    = outstanding < CNT_WIDTH'(MAX_OUTSTANDING);

  // quiet_q swallows stale acks of a job killed by reset until a new start
  always_comb begin
    issued_d = issued_q;
    resp_d   = resp_q;
    err_d    = err_q;
    quiet_d  = quiet_q;
    if (clear_i) begin
      issued_d = '0;
      resp_d   = '0;
      quiet_d  = 1'b0;
    end else begin
      if (issue_i) issued_d = issued_q + CNT_WIDTH'(1);
      if (rsp_ok)  resp_d   = resp_q + CNT_WIDTH'(1);
    end
    if (rsp_i && !rsp_ok && !quiet_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
      quiet_q  <= 1'b1;
    end else begin
      issued_q <= issued_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      quiet_q  <= quiet_d;
    end
  end

  assign issued_o = issued_q;
  assign resp_o   = resp_q;
  assign err_o    = err_q;

endmodule

// File: rtl/loopback_writer.sv
// loopback_writer: drains the loopback FIFO into consecutive line writes.
// LOOPBACK_WRITER_FENCE_EN: issue a write fence before signalling done.
module loopback_writer
  import hc_pkg::*;
#(
  parameter int DATA_WIDTH      = CL_DATA_W,
  parameter int ADDR_WIDTH      = CL_ADDR_W,
  parameter int MDATA_WIDTH     = CL_MDATA_W,
  parameter int CNT_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_lines,
  loopback_writer_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  t_writer_state state_q, state_d;

  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CNT_WIDTH-1:0]   lines_q, lines_d;
  logic                   wr_valid_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [MDATA_WIDTH-1:0] wr_mdata_q;

  logic                   accept;
  logic                   issue;
  logic                   credit;
  logic [CNT_WIDTH-1:0]   issued;
  logic [CNT_WIDTH-1:0]   resp;

  assign accept = start &&
                  (state_q == WR_IDLE || state_q == WR_DONE);

  assign issue = (state_q == WR_RUN) &&
                 !bus.fifo_empty &&
                 !bus.wr_almost_full &&
                 (issued < lines_q) &&
                 credit;

  loopback_writer_credit #(
    .CNT_WIDTH       (CNT_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept),
    .issue_i  (issue),
    .rsp_i    (bus.wr_rsp_valid),
    .active_i (busy),
    .issued_o (issued),
    .resp_o   (resp),
    .credit_o (credit),
    .err_o    (err)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    lines_d = lines_q;
    unique case (state_q)
      WR_IDLE, WR_DONE: begin
        if (accept) begin
          base_d  = base_addr;
          lines_d = num_lines;
          state_d = (num_lines == '0) ? WR_DRAIN : WR_RUN;
        end
      end
      WR_RUN: begin
        if (issue && issued == lines_q - CNT_WIDTH'(1))
          state_d = WR_DRAIN;
      end
      WR_DRAIN: begin
        if (resp == lines_q) begin
`ifdef LOOPBACK_WRITER_FENCE_EN
          state_d = WR_FENCE;
`else
          state_d = WR_DONE;
`endif
        end
      end
`ifdef LOOPBACK_WRITER_FENCE_EN
      WR_FENCE: begin
        if (!bus.wr_almost_full) state_d = WR_FWAIT;
      end
      WR_FWAIT: begin
        if (bus.wr_fence_rsp) state_d = WR_DONE;
      end
`endif
      default: state_d = WR_IDLE;
    endcase
  end

  // request register: address wraps silently at ADDR_WIDTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WR_IDLE;
      base_q     <= '0;
      lines_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_mdata_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      lines_q    <= lines_d;
      wr_valid_q <= issue;
      if (issue) begin
        wr_addr_q  <= base_q + ADDR_WIDTH'(issued);
        wr_data_q  <= bus.fifo_data;
        wr_mdata_q <= issued[MDATA_WIDTH-1:0];
      end
    end
  end

`ifdef LOOPBACK_WRITER_FENCE_EN
  logic wr_fence_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_fence_q <= 1'b0;
    else       wr_fence_q <= (state_q == WR_FENCE) && !bus.wr_almost_full;
  end

  assign bus.wr_fence = wr_fence_q;
`endif

  assign bus.fifo_deq = issue;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_mdata = wr_mdata_q;

  assign busy = !(state_q == WR_IDLE || state_q == WR_DONE);
  assign done = (state_q == WR_DONE);

endmodule
